serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 21 ++
 rtl/serial_add_ctrl_if.sv | 24 ++
 rtl/serial_add_ctrl_fa_bit_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 115 +++++++++++
 tb/tb_serial_add_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings and
// the constant log2 helper used to size the bit counter.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, evaluated at elaboration time for counter sizing.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the bit-serial adder.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cy;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cy
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cy
    );

endinterface

// File: rtl/serial_add_ctrl_fa_bit_cell.sv
// Single combinational full-adder cell shared across every bit position.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell LSB-first over
// WIDTH cycles and presents {Cy,S} with a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = clog2(WIDTH) + 1;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_bit;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-2:0]   s_sr;
    logic [WIDTH-1:0]   s_shift;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   s_q;
    logic               cy_q;
    logic               busy_q;
    logic               done_q;

    logic               fa_s;
    logic               fa_co;

    fa_bit_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // Sum bits enter at the MSB; after WIDTH shifts the first one sits at bit 0.
    assign s_shift  = {fa_s, s_sr};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cy_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == ST_RUN);
            done_q <= (state_nxt == ST_DONE);
            if (accept) begin
                a_sr  <= bus.A;
                b_sr  <= bus.B;
                carry <= bus.Cin;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= s_shift[WIDTH-1:1];
                carry <= fa_co;
                cnt   <= cnt + 1'b1;
                // Visible result only changes on the step into DONE.
                if (last_bit) begin
                    s_q  <= s_shift;
                    cy_q <= fa_co;
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cy   = cy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a WIDTH=8 instance for directed and
// random traffic, and a WIDTH=4 instance for the full operand sweep.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int checks = 0;
    int passed = 0;
    int edge_n = 0;
    int last_acc [2] = '{-100, -100};
    bit in_flight [2] = '{1'b0, 1'b0};
    logic [32:0] held [2] = '{33'd0, 33'd0};
    int n_acc [2] = '{0, 0};
    int n_done [2] = '{0, 0};
    logic [32:0] q8 [$];
    logic [32:0] q4 [$];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    endtask

    // Reference: an accepted start occupies WIDTH busy cycles then one done cycle;
    // the result is plain integer addition.
    task automatic model_dut(input int d, input int w, input logic st,
                             input logic [31:0] a, input logic [31:0] b, input logic c,
                             input logic bsy, input logic dn,
                             input logic [31:0] s, input logic cy);
        logic [32:0] r;
        logic [32:0] got;
        int age;
        if (!rst_n) begin
            in_flight[d] = 1'b0;
            held[d] = '0;
            if (d == 0) q8.delete(); else q4.delete();
        end else if (st && (!in_flight[d] || (edge_n - last_acc[d]) >= w + 1)) begin
            in_flight[d] = 1'b1;
            last_acc[d] = edge_n;
            r = 33'(a) + 33'(b) + 33'(c);
            if (d == 0) q8.push_back(r); else q4.push_back(r);
            n_acc[d]++;
        end
        age = edge_n - last_acc[d];
        chk(d == 0 ? "busy8" : "busy4", 33'(bsy), 33'(in_flight[d] && age <= w - 1));
        chk(d == 0 ? "done8" : "done4", 33'(dn), 33'(in_flight[d] && age == w));
        got = (33'(cy) << w) | 33'(s);
        if (dn) begin
            n_done[d]++;
            if ((d == 0 && q8.size() == 0) || (d == 1 && q4.size() == 0)) begin
                checks++;
                $display("FAIL unexpected_done%0d @edge %0d: got done=1 expected no pending result", d, edge_n);
            end else begin
                r = (d == 0) ? q8.pop_front() : q4.pop_front();
                chk(d == 0 ? "result8" : "result4", got, r);
                held[d] = r;
            end
        end else begin
            chk(d == 0 ? "hold8" : "hold4", got, held[d]);
        end
    endtask

    // Monitor: inputs are still those seen at the preceding posedge.
    always @(negedge clk) begin
        edge_n++;
        model_dut(0, 8, bus8.start, 32'(bus8.A), 32'(bus8.B), bus8.Cin,
                  bus8.busy, bus8.done, 32'(bus8.S), bus8.Cy);
        model_dut(1, 4, bus4.start, 32'(bus4.A), 32'(bus4.B), bus4.Cin,
                  bus4.busy, bus4.done, 32'(bus4.S), bus4.Cy);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.start = 1'b1;
        bus8.A = a;
        bus8.B = b;
        bus8.Cin = c;
        step(1);
        bus8.start = 1'b0;
    endtask

    int vals [512];

    initial begin
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        go8(8'h5A, 8'h3C, 1'b0); step(12);
        go8(8'hFF, 8'h01, 1'b0); step(12);
        go8(8'hFF, 8'h00, 1'b1); step(12);

        go8(8'h01, 8'h01, 1'b0); step(2);
        go8(8'hFF, 8'h01, 1'b0); step(12);

        go8(8'hC3, 8'h77, 1'b1); step(3);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1; step(12);

        bus8.start = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20; bus8.Cin = 1'b0;
        step(9);
        bus8.A = 8'h7F; bus8.B = 8'h01;
        step(9);
        bus8.start = 1'b0;
        step(12);

        for (int i = 0; i < 400; i++) begin
            bus8.start = ($urandom_range(0, 3) == 0);
            bus8.A = 8'($urandom);
            bus8.B = 8'($urandom);
            bus8.Cin = 1'($urandom);
            rst_n = ($urandom_range(0, 79) != 0);
            step(1);
        end
        bus8.start = 1'b0;
        rst_n = 1'b1;
        step(12);

        for (int i = 0; i < 512; i++) vals[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = vals[i]; vals[i] = vals[j]; vals[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(vals[i]);
            bus4.start = 1'b1;
            bus4.A = v[3:0];
            bus4.B = v[7:4];
            bus4.Cin = v[8];
            step(1);
            bus4.start = 1'b0;
            step(4);
        end
        step(10);

        chk("pending8", 33'(q8.size()), 33'd0);
        chk("pending4", 33'(q4.size()), 33'd0);
        chk("accepts4", 33'(n_acc[1]), 33'd512);
        chk("dones4", 33'(n_done[1]), 33'd512);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
